// File: rtl/pa_rvfpm.sv
// Shared types and constants for the FPU result path: default widths, source
// indices of the fixed producers and the per-source result record.
package pa_rvfpm;

  localparam int X_ID_WIDTH_DEF = 4;
  localparam int FLEN_DEF       = 32;

  localparam int RES_SRC_ALU = 0;
  localparam int RES_SRC_LSU = 1;

  typedef struct packed {
    logic [X_ID_WIDTH_DEF-1:0] id;
    logic [4:0]                rd;
    logic [FLEN_DEF-1:0]       data;
    logic                      we;
  } rvfpm_res_src_t;

endpackage

// File: rtl/rvfpm_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer just past the winner when a transfer happens.
module rvfpm_rr_arbiter
  import pa_rvfpm::*;
#(
  parameter int N = 2
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  input  logic [$clog2(N)-1:0] winner_idx,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] r_ptr;
  logic [IW:0]   w_cand;
  logic [IW-1:0] w_idx;
  logic          w_found;

  // NOTE: every signal driven in always_comb gets a default first, otherwise
  // paths that skip an assignment infer a latch.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    w_idx     = '0;
    for (int off = 0; off < N; off++) begin
      w_cand = {1'b0, r_ptr} + (IW+1)'(off);
      if (w_cand >= (IW+1)'(N)) begin
        w_cand = w_cand - (IW+1)'(N);
      end
      w_idx = w_cand[IW-1:0];
      if (!w_found && req[w_idx]) begin
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
        w_found      = 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values regardless of block order.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_ptr <= IW'(RES_SRC_ALU);
    end else if (advance) begin
      r_ptr <= (winner_idx == IW'(N-1)) ? '0 : winner_idx + 1'b1;
    end
  end

endmodule

// File: rtl/rvfpm_result_arbiter.sv
// Shares the single X-IF result port between N_SRC FPU result producers through
// a round-robin grant and one output register that holds under backpressure.
module rvfpm_result_arbiter
  import pa_rvfpm::*;
#(
  parameter int N_SRC      = 2,
  parameter int X_ID_WIDTH = X_ID_WIDTH_DEF,
  parameter int FLEN       = FLEN_DEF,
  parameter int STALL_W    = 16
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic                        flush,
  input  logic [N_SRC-1:0]            src_valid,
  output logic [N_SRC-1:0]            src_ready,
  input  logic [N_SRC*X_ID_WIDTH-1:0] src_id,
  input  logic [N_SRC*5-1:0]          src_rd,
  input  logic [N_SRC*FLEN-1:0]       src_data,
  input  logic [N_SRC-1:0]            src_we,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic [X_ID_WIDTH-1:0]       result_id,
  output logic [4:0]                  result_rd,
  output logic [FLEN-1:0]             result_data,
  output logic                        result_we,
  output logic [$clog2(N_SRC)-1:0]    result_src,
  output logic [STALL_W-1:0]          stall_cnt
);

  localparam int SRC_W = $clog2(N_SRC);

  logic [N_SRC-1:0]      w_grant;
  logic [SRC_W-1:0]      w_grant_idx;
  logic                  w_slot_free;
  logic                  w_xfer;
  logic [X_ID_WIDTH-1:0] w_sel_id;
  logic [4:0]            w_sel_rd;
  logic [FLEN-1:0]       w_sel_data;
  logic                  w_sel_we;

  logic                  r_valid;
  logic [X_ID_WIDTH-1:0] r_id;
  logic [4:0]            r_rd;
  logic [FLEN-1:0]       r_data;
  logic                  r_we;
  logic [SRC_W-1:0]      r_src;
  logic [STALL_W-1:0]    r_stall;

  rvfpm_rr_arbiter #(.N(N_SRC)) u_rr (
    .ck         (ck),
    .rst        (rst),
    .req        (src_valid),
    .advance    (w_xfer),
    .winner_idx (w_grant_idx),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // Ready is gated by reset so no handshake can complete while rst is held.
  assign w_slot_free = !r_valid || result_ready;
  assign src_ready   = w_grant & {N_SRC{w_slot_free && !flush && rst}};
  assign w_xfer      = |src_ready;

  always_comb begin
    w_sel_id   = '0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    w_sel_we   = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_grant[i]) begin
        w_sel_id   = src_id[i*X_ID_WIDTH +: X_ID_WIDTH];
        w_sel_rd   = src_rd[i*5 +: 5];
        w_sel_data = src_data[i*FLEN +: FLEN];
        w_sel_we   = src_we[i];
      end
    end
  end

  // NOTE: the data fields are reset too, because the X-IF outputs must read
  // as zero after reset, not merely be masked by result_valid.
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_id    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_we    <= 1'b0;
      r_src   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_id    <= w_sel_id;
      r_rd    <= w_sel_rd;
      r_data  <= w_sel_data;
      r_we    <= w_sel_we;
      r_src   <= w_grant_idx;
    end else if (result_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      r_stall <= '0;
    end else if (!flush && r_valid && !result_ready && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign result_valid = r_valid;
  assign result_id    = r_id;
  assign result_rd    = r_rd;
  assign result_data  = r_data;
  assign result_we    = r_we;
  assign result_src   = r_src;
  assign stall_cnt    = r_stall;

endmodule

// File: tb/tb_rvfpm_result_arbiter.sv
// Self-checking bench for rvfpm_result_arbiter: directed scenarios followed by
// randomized traffic, checked against a cycle-level transaction model.
module tb_rvfpm_result_arbiter;
  import pa_rvfpm::*;

  localparam int N  = 2;
  localparam int XW = 4;
  localparam int FL = 32;
  localparam int SW = 4;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic            ck = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic [N-1:0]    src_valid = '0;
  logic [N-1:0]    src_ready;
  logic [N*XW-1:0] src_id = '0;
  logic [N*5-1:0]  src_rd = '0;
  logic [N*FL-1:0] src_data = '0;
  logic [N-1:0]    src_we = '0;
  logic            result_valid;
  logic            result_ready = 1'b1;
  logic [XW-1:0]   result_id;
  logic [4:0]      result_rd;
  logic [FL-1:0]   result_data;
  logic            result_we;
  logic [0:0]      result_src;
  logic [SW-1:0]   stall_cnt;

  always #5 ck = ~ck;

  rvfpm_result_arbiter #(.N_SRC(N), .X_ID_WIDTH(XW), .FLEN(FL), .STALL_W(SW)) dut (
    .ck           (ck),
    .rst          (rst),
    .flush        (flush),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .src_id       (src_id),
    .src_rd       (src_rd),
    .src_data     (src_data),
    .src_we       (src_we),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_id    (result_id),
    .result_rd    (result_rd),
    .result_data  (result_data),
    .result_we    (result_we),
    .result_src   (result_src),
    .stall_cnt    (stall_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model of the output slot
  int             m_ptr;
  bit             m_valid;
  int             m_src;
  rvfpm_res_src_t m_res;
  int             m_stall;
  int             dut_log[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr   = RES_SRC_ALU;
    m_valid = 1'b0;
    m_src   = 0;
    m_res   = '0;
    m_stall = 0;
  endtask

  function automatic rvfpm_res_src_t src_fields(input int i);
    rvfpm_res_src_t r;
    r.id   = src_id[i*XW +: XW];
    r.rd   = src_rd[i*5 +: 5];
    r.data = src_data[i*FL +: FL];
    r.we   = src_we[i];
    return r;
  endfunction

  // Index of the source that should transfer this cycle, or -1
  function automatic int winner();
    if (!rst || flush) return -1;
    if (m_valid && !result_ready) return -1;
    for (int off = 0; off < N; off++) begin
      if (src_valid[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic set_src(input int i, input logic v, input logic [XW-1:0] id,
                         input logic [4:0] rd, input logic [FL-1:0] data, input logic we);
    src_valid[i]          = v;
    src_id[i*XW +: XW]    = id;
    src_rd[i*5 +: 5]      = rd;
    src_data[i*FL +: FL]  = data;
    src_we[i]             = we;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge
  task automatic step(input string tag);
    int             w;
    logic [N-1:0]   exp_ready;
    bit             n_valid;
    int             n_ptr, n_src, n_stall;
    rvfpm_res_src_t n_res;
    @(negedge ck);
    w = winner();
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    check({tag, ".src_ready"}, src_ready, exp_ready);
    check({tag, ".valid"}, result_valid, m_valid);
    check({tag, ".stall"}, stall_cnt, m_stall);
    if (m_valid) begin
      check({tag, ".src"}, result_src, m_src);
      check({tag, ".id"}, result_id, m_res.id);
      check({tag, ".rd"}, result_rd, m_res.rd);
      check({tag, ".data"}, result_data, m_res.data);
      check({tag, ".we"}, result_we, m_res.we);
    end
    if (src_ready[1]) dut_log.push_back(1);
    else if (src_ready[0]) dut_log.push_back(0);
    n_valid = m_valid; n_ptr = m_ptr; n_src = m_src; n_res = m_res; n_stall = m_stall;
    if (m_valid && !result_ready && !flush && m_stall < STALL_MAX) n_stall = m_stall + 1;
    if (flush) n_valid = 1'b0;
    else if (w >= 0) begin
      n_valid = 1'b1;
      n_res   = src_fields(w);
      n_src   = w;
      n_ptr   = (w + 1) % N;
    end else if (result_ready) n_valid = 1'b0;
    @(posedge ck);
    m_valid = n_valid; m_ptr = n_ptr; m_src = n_src; m_res = n_res; m_stall = n_stall;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    @(posedge ck);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    // 1: reset with both sources requesting
    model_reset();
    set_src(0, 1'b1, 4'h1, 5'd1, 32'h1111_0000, 1'b1);
    set_src(1, 1'b1, 4'h2, 5'd2, 32'h2222_0000, 1'b0);
    #2;
    check("t1.valid", result_valid, 1'b0);
    check("t1.src_ready", src_ready, 2'b00);
    check("t1.stall", stall_cnt, 0);
    check("t1.data", result_data, 0);
    @(posedge ck);
    #1;
    rst = 1'b1;

    // 2: both valid, sink always ready -> strict alternation
    dut_log.delete();
    repeat (4) step("t2");
    for (int k = 0; k < 4; k++) check($sformatf("t2.grant%0d", k), dut_log[k], k % 2);

    // 3: capture src0, stall five cycles, then hand over to src1
    do_reset();
    set_src(0, 1'b1, 4'd3, 5'd5, 32'h3F80_0000, 1'b1);
    set_src(1, 1'b1, 4'd9, 5'd7, 32'h4000_0000, 1'b0);
    result_ready = 1'b0;
    step("t3.load");
    repeat (5) step("t3.hold");
    check("t3.held_id", result_id, 4'd3);
    check("t3.held_data", result_data, 32'h3F80_0000);
    result_ready = 1'b1;
    #1;
    check("t3.stall5", stall_cnt, 5);
    check("t3.ready_src1", src_ready, 2'b10);
    step("t3.hs");
    check("t3.src1", result_src, RES_SRC_LSU);
    check("t3.id1", result_id, 4'd9);

    // 4: only src1 valid with pointer at 0
    do_reset();
    src_valid = 2'b10;
    #1;
    check("t4.grant1", src_ready, 2'b10);
    step("t4.only1");
    src_valid = 2'b11;
    #1;
    check("t4.ptr0", src_ready, 2'b01);
    step("t4.next");

    // 5: flush wins over result_ready and keeps the pointer
    flush = 1'b1;
    #1;
    check("t5.no_ready", src_ready, 2'b00);
    step("t5.flush");
    flush = 1'b0;
    #1;
    check("t5.dropped", result_valid, 1'b0);
    check("t5.ptr_kept", src_ready, 2'b10);
    step("t5.after");

    // 6: long stall saturates the counter
    result_ready = 1'b0;
    repeat (20) step("t6");
    check("t6.sat", stall_cnt, STALL_MAX);

    // 7: asynchronous reset in the middle of a stall
    @(negedge ck);
    #1;
    rst = 1'b0;
    #1;
    check("t7.valid", result_valid, 1'b0);
    check("t7.stall", stall_cnt, 0);
    check("t7.src_ready", src_ready, 2'b00);
    model_reset();
    @(posedge ck);
    #1;
    rst = 1'b1;
    result_ready = 1'b1;
    #1;
    check("t7.ptr0", src_ready, 2'b01);
    step("t7.resume");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        set_src(i, 1'($urandom_range(0, 1)), XW'($urandom), 5'($urandom), $urandom, 1'($urandom));
      end
      result_ready = ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 15) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
